// File: rtl/axi4_config_master.sv
// axi4_config_master: turns index/data register requests into single-beat AXI4 reads and writes
module axi4_config_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] CONF_OFFSET = 32'h01,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 32,
    parameter int MST_ID_W     = 5,
    parameter logic [MST_ID_W-1:0] MST_ID = 5'd0,
    parameter int TRANS_RESP_W = 2,
    parameter int CONF_ADDR_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_vld_i,
    output logic                    req_rdy_o,
    input  logic                    req_wr_i,
    input  logic [CONF_ADDR_W-1:0]  req_idx_i,
    input  logic [DATA_W-1:0]       req_wdata_i,
    output logic                    rsp_vld_o,
    input  logic                    rsp_rdy_i,
    output logic [TRANS_RESP_W-1:0] rsp_resp_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    output logic [MST_ID_W-1:0]     m_awid_o,
    output logic [ADDR_W-1:0]       m_awaddr_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_W-1:0]       m_wdata_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [MST_ID_W-1:0]     m_bid_i,
    input  logic [TRANS_RESP_W-1:0] m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [MST_ID_W-1:0]     m_arid_o,
    output logic [ADDR_W-1:0]       m_araddr_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [MST_ID_W-1:0]     m_rid_i,
    input  logic [DATA_W-1:0]       m_rdata_i,
    input  logic [TRANS_RESP_W-1:0] m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
    state_t state, state_n;
    logic aw_done, w_done, aw_done_n, w_done_n;
    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [ADDR_W-1:0] req_addr;

    assign m_awid_o = MST_ID;
    assign m_arid_o = MST_ID;
    assign req_addr = ADDR_W'(BASE_ADDR + 32'(req_idx_i) * CONF_OFFSET);

    always_comb begin
        accept    = req_vld_i & req_rdy_o;
        aw_hs     = m_awvalid_o & m_awready_i;
        w_hs      = m_wvalid_o & m_wready_i;
        b_hs      = m_bvalid_i & m_bready_o;
        ar_hs     = m_arvalid_o & m_arready_i;
        r_hs      = m_rvalid_i & m_rready_o;
        aw_done_n = (state == WR_REQ) & (aw_done | aw_hs);
        w_done_n  = (state == WR_REQ) & (w_done | w_hs);
        state_n   = state;
        case (state)
            IDLE:    if (accept) state_n = req_wr_i ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_done_n & w_done_n) state_n = WR_RESP;
            WR_RESP: if (b_hs) state_n = RSP;
            RD_REQ:  if (ar_hs) state_n = RD_RESP;
            RD_RESP: if (r_hs) state_n = RSP;
            RSP:     if (rsp_rdy_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // Handshake outputs are registered copies of the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            req_rdy_o   <= 1'b1;
            busy_o      <= 1'b0;
            rsp_vld_o   <= 1'b0;
            m_awvalid_o <= 1'b0;
            m_wvalid_o  <= 1'b0;
            m_bready_o  <= 1'b0;
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b0;
            m_awaddr_o  <= '0;
            m_araddr_o  <= '0;
            m_wdata_o   <= '0;
            rsp_resp_o  <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            req_rdy_o   <= state_n == IDLE;
            busy_o      <= state_n != IDLE;
            rsp_vld_o   <= state_n == RSP;
            m_awvalid_o <= (state_n == WR_REQ) && !aw_done_n;
            m_wvalid_o  <= (state_n == WR_REQ) && !w_done_n;
            m_bready_o  <= state_n == WR_RESP;
            m_arvalid_o <= state_n == RD_REQ;
            m_rready_o  <= state_n == RD_RESP;
            if (accept && req_wr_i) begin
                m_awaddr_o <= req_addr;
                m_wdata_o  <= req_wdata_i;
            end
            if (accept && !req_wr_i) m_araddr_o <= req_addr;
            if (b_hs) begin
                rsp_resp_o  <= m_bresp_i;
                rsp_rdata_o <= '0;
                rsp_err_o   <= (m_bresp_i != '0) || (m_bid_i != MST_ID);
            end
            if (r_hs) begin
                rsp_resp_o  <= m_rresp_i;
                rsp_rdata_o <= m_rdata_i;
                rsp_err_o   <= (m_rresp_i != '0) || (m_rid_i != MST_ID);
            end
        end
    end
endmodule

// File: tb/tb_axi4_config_master.sv
// tb_axi4_config_master: directed scenarios with hand-computed expectations for axi4_config_master
module tb_axi4_config_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_vld = 1'b0, req_rdy, req_wr = 1'b0;
    logic [3:0] req_idx = '0;
    logic [7:0] req_wdata = '0;
    logic rsp_vld, rsp_rdy = 1'b0, rsp_err, busy;
    logic [1:0] rsp_resp;
    logic [7:0] rsp_rdata;
    logic [4:0] awid, arid;
    logic [31:0] awaddr, araddr;
    logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bready, arvalid, arready = 1'b0, rready;
    logic [7:0] wdata;
    logic [4:0] bid = '0, rid = '0;
    logic [1:0] bresp = '0, rresp = '0;
    logic bvalid = 1'b0, rvalid = 1'b0;
    logic [7:0] rdata = '0;
    int errors = 0;
    int checks = 0;

    axi4_config_master dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_wr_i(req_wr), .req_idx_i(req_idx), .req_wdata_i(req_wdata),
        .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_resp_o(rsp_resp), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .busy_o(busy),
        .m_awid_o(awid), .m_awaddr_o(awaddr), .m_awvalid_o(awvalid), .m_awready_i(awready),
        .m_wdata_o(wdata), .m_wvalid_o(wvalid), .m_wready_i(wready),
        .m_bid_i(bid), .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready),
        .m_arid_o(arid), .m_araddr_o(araddr), .m_arvalid_o(arvalid), .m_arready_i(arready),
        .m_rid_i(rid), .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rvalid_i(rvalid), .m_rready_o(rready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ack_rsp;
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    // Runs a write until the response is being presented
    task automatic drive_write(input logic [3:0] idx, input logic [7:0] d, input logic [1:0] r, input logic [4:0] id);
        req_vld = 1'b1; req_wr = 1'b1; req_idx = idx; req_wdata = d;
        awready = 1'b1; wready = 1'b1;
        tick();
        req_vld = 1'b0;
        tick();
        bvalid = 1'b1; bresp = r; bid = id;
        tick();
        bvalid = 1'b0; bresp = '0; bid = '0; awready = 1'b0; wready = 1'b0;
    endtask

    task automatic drive_read(input logic [3:0] idx, input logic [7:0] d, input logic [1:0] r, input logic [4:0] id);
        req_vld = 1'b1; req_wr = 1'b0; req_idx = idx;
        arready = 1'b1;
        tick();
        req_vld = 1'b0;
        tick();
        rvalid = 1'b1; rdata = d; rresp = r; rid = id;
        tick();
        rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; arready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL rst_req_rdy: got %b want 1", req_rdy); end
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_vld, busy} !== 7'b0) begin errors++; $display("FAIL rst_valids: got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, rsp_vld, busy}); end
        checks++; if ({awaddr, araddr, wdata} !== 72'h0) begin errors++; $display("FAIL rst_addr_data: got %h %h %h want 0", awaddr, araddr, wdata); end
        checks++; if ({rsp_resp, rsp_rdata, rsp_err} !== 11'h0) begin errors++; $display("FAIL rst_rsp: got %b %h %b want 0", rsp_resp, rsp_rdata, rsp_err); end
        checks++; if ({awid, arid} !== 10'h0) begin errors++; $display("FAIL rst_ids: got %h %h want 0", awid, arid); end
    endtask

    task automatic test_read_basic;
        req_vld = 1'b1; req_wr = 1'b0; req_idx = 4'd0;
        tick();
        req_vld = 1'b0;
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid: got %b want 1", arvalid); end
        checks++; if (araddr !== 32'h3000_0000) begin errors++; $display("FAIL rd_araddr: got %h want 30000000", araddr); end
        checks++; if ({req_rdy, busy, rready} !== 3'b010) begin errors++; $display("FAIL rd_req_phase: got %b want 010", {req_rdy, busy, rready}); end
        tick();
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid_hold: got %b want 1", arvalid); end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_rready: got %b want 01", {arvalid, rready}); end
        rvalid = 1'b1; rdata = 8'h01; rresp = 2'b00; rid = 5'd0;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++; if ({rsp_vld, rready} !== 2'b10) begin errors++; $display("FAIL rd_rsp_vld: got %b want 10", {rsp_vld, rready}); end
        checks++; if ({rsp_rdata, rsp_resp, rsp_err} !== {8'h01, 2'b00, 1'b0}) begin errors++; $display("FAIL rd_rsp: got %h %b %b want 01 00 0", rsp_rdata, rsp_resp, rsp_err); end
        ack_rsp();
        checks++; if ({rsp_vld, req_rdy, busy} !== 3'b010) begin errors++; $display("FAIL rd_idle: got %b want 010", {rsp_vld, req_rdy, busy}); end
    endtask

    task automatic test_write_basic;
        req_vld = 1'b1; req_wr = 1'b1; req_idx = 4'd3; req_wdata = 8'h2A;
        tick();
        req_vld = 1'b0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b110) begin errors++; $display("FAIL wr_valids: got %b want 110", {awvalid, wvalid, bready}); end
        checks++; if (awaddr !== 32'h3000_0003) begin errors++; $display("FAIL wr_awaddr: got %h want 30000003", awaddr); end
        checks++; if (wdata !== 8'h2A) begin errors++; $display("FAIL wr_wdata: got %h want 2a", wdata); end
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr_bready: got %b want 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00; bid = 5'd0;
        tick();
        bvalid = 1'b0;
        checks++; if ({rsp_vld, bready} !== 2'b10) begin errors++; $display("FAIL wr_rsp_vld: got %b want 10", {rsp_vld, bready}); end
        checks++; if ({rsp_rdata, rsp_resp, rsp_err} !== {8'h00, 2'b00, 1'b0}) begin errors++; $display("FAIL wr_rsp: got %h %b %b want 00 00 0", rsp_rdata, rsp_resp, rsp_err); end
        ack_rsp();
        checks++; if ({rsp_vld, req_rdy} !== 2'b01) begin errors++; $display("FAIL wr_idle: got %b want 01", {rsp_vld, req_rdy}); end
    endtask

    task automatic test_wready_delay;
        req_vld = 1'b1; req_wr = 1'b1; req_idx = 4'd5; req_wdata = 8'hA5;
        awready = 1'b1;
        tick();
        req_vld = 1'b0;
        checks++; if (awaddr !== 32'h3000_0005) begin errors++; $display("FAIL dly_awaddr: got %h want 30000005", awaddr); end
        tick();
        awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin errors++; $display("FAIL dly_wait%0d: got %b want 010", i, {awvalid, wvalid, bready}); end
            checks++; if (wdata !== 8'hA5) begin errors++; $display("FAIL dly_wdata%0d: got %h want a5", i, wdata); end
            if (i == 2) wready = 1'b1;
            tick();
        end
        wready = 1'b0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL dly_bready: got %b want 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = '0;
        checks++; if ({rsp_vld, rsp_resp, rsp_err} !== 4'b1101) begin errors++; $display("FAIL dly_rsp: got %b want 1101", {rsp_vld, rsp_resp, rsp_err}); end
        ack_rsp();
    endtask

    task automatic test_read_errors;
        drive_read(4'hF, 8'h55, 2'b11, 5'd0);
        checks++; if (araddr !== 32'h3000_000F) begin errors++; $display("FAIL rerr_araddr: got %h want 3000000f", araddr); end
        checks++; if ({rsp_vld, rsp_resp, rsp_err, rsp_rdata} !== {1'b1, 2'b11, 1'b1, 8'h55}) begin errors++; $display("FAIL rerr_resp11: got %b %b %b %h want 1 11 1 55", rsp_vld, rsp_resp, rsp_err, rsp_rdata); end
        ack_rsp();
        drive_read(4'd1, 8'h3C, 2'b00, 5'd7);
        checks++; if ({rsp_vld, rsp_resp, rsp_err, rsp_rdata} !== {1'b1, 2'b00, 1'b1, 8'h3C}) begin errors++; $display("FAIL rerr_id: got %b %b %b %h want 1 00 1 3c", rsp_vld, rsp_resp, rsp_err, rsp_rdata); end
        ack_rsp();
        checks++; if ({rsp_vld, req_rdy, rready} !== 3'b010) begin errors++; $display("FAIL rerr_consumed: got %b want 010", {rsp_vld, req_rdy, rready}); end
    endtask

    task automatic test_rsp_hold;
        drive_write(4'd2, 8'h99, 2'b01, 5'd0);
        req_vld = 1'b1; req_wr = 1'b0; req_idx = 4'd4;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({rsp_vld, rsp_resp, rsp_err, rsp_rdata, req_rdy, arvalid} !== {1'b1, 2'b01, 1'b1, 8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL hold%0d: got %b %b %b %h %b %b want 1 01 1 00 0 0", i, rsp_vld, rsp_resp, rsp_err, rsp_rdata, req_rdy, arvalid); end
            tick();
        end
        ack_rsp();
        checks++; if ({rsp_vld, req_rdy, arvalid} !== 3'b010) begin errors++; $display("FAIL hold_release: got %b want 010", {rsp_vld, req_rdy, arvalid}); end
        tick();
        req_vld = 1'b0;
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h3000_0004}) begin errors++; $display("FAIL b2b_accept: got %b %h want 1 30000004", arvalid, araddr); end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 8'h77;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++; if ({rsp_vld, rsp_rdata, rsp_resp, rsp_err} !== {1'b1, 8'h77, 2'b00, 1'b0}) begin errors++; $display("FAIL b2b_rsp: got %b %h %b %b want 1 77 00 0", rsp_vld, rsp_rdata, rsp_resp, rsp_err); end
        ack_rsp();
    endtask

    task automatic test_reset_mid;
        req_vld = 1'b1; req_wr = 1'b1; req_idx = 4'd6; req_wdata = 8'h11;
        awready = 1'b1; wready = 1'b1;
        tick();
        req_vld = 1'b0;
        tick();
        awready = 1'b0; wready = 1'b0;
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL mid_in_resp: got %b want 1", bready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_vld, busy, req_rdy} !== 8'b00000001) begin errors++; $display("FAIL mid_reset: got %b want 00000001", {awvalid, wvalid, arvalid, bready, rready, rsp_vld, busy, req_rdy}); end
        checks++; if ({awaddr, wdata} !== 40'h0) begin errors++; $display("FAIL mid_addr: got %h %h want 0", awaddr, wdata); end
        bvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({rsp_vld, bready, req_rdy} !== 3'b001) begin errors++; $display("FAIL mid_no_rsp%0d: got %b want 001", i, {rsp_vld, bready, req_rdy}); end
        end
        bvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_wready_delay();
        test_read_errors();
        test_rsp_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4_config_master.md
Name: axi4_config_master

Overview:
- AXI4 initiator that turns simple register-access requests (index, write data, read/write) into single-beat AXI4 transactions.
- Drives the display TX configuration register slave, mapped at base 32'h3000_0000 with byte-access offsets.
- Returns the AXI response and read data to the requester over a valid/ready response port.
- Used by the boot/config sequencer to program DBI addresses and column/row commands and to set the TX start bit.

Parameters:
BASE_ADDR, 32'h3000_0000, base of the config register map
CONF_OFFSET, 32'h01, address stride per register (bytes)
DATA_W, 8, AXI data width
ADDR_W, 32, AXI address width
MST_ID_W, 5, AXI ID width
MST_ID, 5'd0, fixed ID driven on AWID/ARID and expected on BID/RID
TRANS_RESP_W, 2, AXI response width
CONF_ADDR_W, 4, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld_i  in  1  request valid
req_rdy_o  out  1  request ready (high only in IDLE)
req_wr_i  in  1  1=write, 0=read
req_idx_i  in  CONF_ADDR_W  register index
req_wdata_i  in  DATA_W  write data
rsp_vld_o  out  1  response valid
rsp_rdy_i  in  1  response ready
rsp_resp_o  out  TRANS_RESP_W  BRESP/RRESP captured
rsp_rdata_o  out  DATA_W  RDATA captured (0 for writes)
rsp_err_o  out  1  resp!=2'b00 or ID mismatch
busy_o  out  1  state!=IDLE
m_awid_o/m_awaddr_o/m_awvalid_o  out  MST_ID_W/ADDR_W/1  AW channel
m_awready_i  in  1
m_wdata_o/m_wvalid_o  out  DATA_W/1  W channel
m_wready_i  in  1
m_bid_i/m_bresp_i/m_bvalid_i  in  MST_ID_W/TRANS_RESP_W/1  B channel
m_bready_o  out  1
m_arid_o/m_araddr_o/m_arvalid_o  out  MST_ID_W/ADDR_W/1  AR channel
m_arready_i  in  1
m_rid_i/m_rdata_i/m_rresp_i/m_rvalid_i  in  MST_ID_W/DATA_W/TRANS_RESP_W/1  R channel
m_rready_o  out  1

Behaviour:
- One clock; reset is synchronous and active-high. On rst: state=IDLE, every valid/ready output 0 except req_rdy_o=1; rsp_resp_o, rsp_rdata_o, rsp_err_o, awaddr, araddr, wdata all 0. IDs are constant MST_ID.
- All AXI and rsp outputs are registered. Only one transaction is outstanding at a time.
- Address = (BASE_ADDR + req_idx_i*CONF_OFFSET) truncated to ADDR_W; address and data latched on request acceptance (req_vld_i & req_rdy_o).
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: on accept, go to WR_REQ (write) or RD_REQ (read). AWVALID/WVALID (or ARVALID) rise the following cycle (1-cycle issue latency).
- WR_REQ: AWVALID and WVALID assert together and each holds until its own handshake. aw_done/w_done flags record completed handshakes. Exit to WR_RESP on the cycle both are done; both may complete in the same cycle, or in either order. Address/data are stable while valid.
- WR_RESP: BREADY=1. On BVALID: capture BRESP, set rdata=0, err=(BRESP!=0)|(BID!=MST_ID), go to RSP. BVALID in any other state is ignored (BREADY=0).
- RD_REQ: ARVALID held until ARREADY, then RD_RESP.
- RD_RESP: RREADY=1. On RVALID: capture RDATA/RRESP, err=(RRESP!=0)|(RID!=MST_ID), go to RSP.
- RSP: rsp_vld_o=1, with outputs stable until rsp_rdy_i, then IDLE. req_rdy_o rises the cycle after the response handshake (no request/response overlap).
- A response with a mismatched ID is still consumed; only the err flag marks it.
- Reset mid-transaction: next edge returns to reset values. No completion response is produced for the abandoned transaction.

Test Plan:
- Write idx 3, data 8'h2A, all readies high -> AWADDR=32'h3000_0003, WDATA=8'h2A; slave B 2'b00 -> rsp_resp=00, err=0, rdata=0.
- Write with WREADY delayed 3 cycles after the AW handshake -> AWVALID drops after its handshake, WVALID holds 3 more cycles, BREADY asserts only after both handshakes.
- Read idx 0, slave returns RDATA=8'h01, RRESP=00 -> ARADDR=32'h3000_0000, rsp_rdata=8'h01, err=0.
- Slave returns RRESP=2'b11, then on the next read RID=5'd7 -> err=1 both times; rsp_resp=11 and 00 respectively.
- Hold rsp_rdy_i low 5 cycles -> rsp_vld, resp, rdata stable; req_rdy_o=0; a new req_vld_i is not accepted until after the response handshake.
- Assert rst in WR_RESP before BVALID -> next cycle all valids=0, BREADY=0, req_rdy_o=1, and no rsp_vld_o.
